// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS32 IF stage owning the PC and IF/ID register, with stall and redirect control.
// Optional perf counters (fetch_cnt, bubble_cnt) are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        addr_err,
  output logic        oor_fetch
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  logic [31:0] pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d;
  logic        valid_q, valid_d, aerr_q, aerr_d, oor_q, oor_d;
  logic        in_range;
  assign in_range = pc_q < 32'(IMEM_BYTES);
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    aerr_d  = 1'b0;
    oor_d   = 1'b0;
    if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
      aerr_d  = |redirect_target[1:0];
    end else if (!stall) begin
      pc_d    = pc_q + 32'd4;
      pc4_d   = pc_q + 32'd4;
      instr_d = in_range ? instruction : '0;
      valid_d = in_range;
      oor_d   = !in_range;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
      oor_q   <= oor_d;
    end
  end
  assign pc          = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign addr_err    = aerr_q;
  assign oor_fetch   = oor_q;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        fetch_inc, bubble_inc;
  // both counters saturate at all-ones rather than wrapping
  assign fetch_inc  = !redirect_valid && !stall && in_range && ~&fetch_cnt_q;
  assign bubble_inc = (redirect_valid || (!stall && !in_range)) && ~&bubble_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + {31'd0, fetch_inc};
      bubble_cnt_q <= bubble_cnt_q + {31'd0, bubble_inc};
    end
  end
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized + directed bench for if_fetch_stage against a behavioural model.
module tb_if_fetch_stage;
  localparam int unsigned IMEM = 32;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instruction;
  logic [31:0] pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, addr_err, oor_fetch;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
  logic [31:0] m_fc, m_bc;
`endif
  logic [31:0] rom [8];
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_aerr, m_oor;
  int total = 0;
  int bad = 0;

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instruction(instruction), .pc(pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .addr_err(addr_err), .oor_fetch(oor_fetch)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns a recognisable junk word beyond IMEM so a wrongly kept capture is visible.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a < IMEM) ? rom[a[4:2]] : (32'hBAD0_0000 ^ a);
  endfunction
  assign instruction = word_at(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= 32'h0; m_pc4 <= 0; m_instr <= 0; m_valid <= 0; m_aerr <= 0; m_oor <= 0;
`ifdef IF_PERF_CNT_EN
      m_fc <= 0; m_bc <= 0;
`endif
    end else if (redirect_valid) begin
      m_pc <= redirect_target & ~32'd3;
      m_pc4 <= 0; m_instr <= 0; m_valid <= 0; m_oor <= 0;
      m_aerr <= (redirect_target % 4) != 0;
`ifdef IF_PERF_CNT_EN
      if (m_bc != 32'hFFFF_FFFF) m_bc <= m_bc + 1;
`endif
    end else if (stall) begin
      m_aerr <= 0; m_oor <= 0;
    end else begin
      m_pc <= m_pc + 4;
      m_pc4 <= m_pc + 4;
      m_aerr <= 0;
      m_valid <= m_pc < IMEM;
      m_oor <= m_pc >= IMEM;
      m_instr <= (m_pc < IMEM) ? word_at(m_pc) : 32'h0;
`ifdef IF_PERF_CNT_EN
      if (m_pc < IMEM && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
      if (m_pc >= IMEM && m_bc != 32'hFFFF_FFFF) m_bc <= m_bc + 1;
`endif
    end
  end

  always @(negedge clk) begin
    chk("m_pc", pc, m_pc);
    chk("m_pc4", if_id_pc4, m_pc4);
    chk("m_instr", if_id_instr, m_instr);
    chk("m_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("m_aerr", {31'd0, addr_err}, {31'd0, m_aerr});
    chk("m_oor", {31'd0, oor_fetch}, {31'd0, m_oor});
`ifdef IF_PERF_CNT_EN
    chk("m_fcnt", fetch_cnt, m_fc);
    chk("m_bcnt", bubble_cnt, m_bc);
`endif
  end

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect_valid = r; redirect_target = t;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = $urandom;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    reset = 1'b1;
    step(0, 0, 0);
    chk("pc4", pc, 32'd4); chk("pc4_a", if_id_pc4, 32'd4); chk("ins0", if_id_instr, rom[0]);
    step(0, 0, 0);
    chk("pc8", pc, 32'd8); chk("pc4_b", if_id_pc4, 32'd8); chk("ins1", if_id_instr, rom[1]);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("stall_pc", pc, 32'd8); chk("stall_pc4", if_id_pc4, 32'd8); chk("stall_ins", if_id_instr, rom[1]);
    step(0, 0, 0);
    chk("post_stall_pc", pc, 32'd12); chk("post_stall_ins", if_id_instr, rom[2]);
    step(0, 0, 0);
    chk("pc16", pc, 32'd16);
    step(1, 1, 32'd4);
    chk("redir_pc", pc, 32'd4); chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_ins", if_id_instr, 32'd0); chk("redir_aerr", {31'd0, addr_err}, 32'd0);
    step(0, 0, 0);
    chk("after_redir_ins", if_id_instr, rom[1]); chk("after_redir_pc4", if_id_pc4, 32'd8);
    step(0, 1, 32'h0000_000E);
    chk("mis_pc", pc, 32'd12); chk("mis_aerr", {31'd0, addr_err}, 32'd1);
    step(0, 0, 0);
    chk("mis_aerr_clr", {31'd0, addr_err}, 32'd0);
    step(0, 1, 32'd28);
    step(0, 0, 0);
    chk("edge_valid", {31'd0, if_id_valid}, 32'd1); chk("edge_pc4", if_id_pc4, 32'd32);
    chk("edge_ins", if_id_instr, rom[7]);
    step(0, 0, 0);
    chk("oor_valid", {31'd0, if_id_valid}, 32'd0); chk("oor_ins", if_id_instr, 32'd0);
    chk("oor_flag", {31'd0, oor_fetch}, 32'd1);
    step(0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("wrap_pc", pc, 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 15);
      t = ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 47));
      step($urandom_range(0, 99) < 25, r, t);
    end
    step(0, 0, 0);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0013;
    #2 reset = 1'b0;
    #1;
    chk("async_pc", pc, 32'd0); chk("async_pc4", if_id_pc4, 32'd0);
    chk("async_ins", if_id_instr, 32'd0); chk("async_valid", {31'd0, if_id_valid}, 32'd0);
    chk("async_aerr", {31'd0, addr_err}, 32'd0); chk("async_oor", {31'd0, oor_fetch}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("async_fcnt", fetch_cnt, 32'd0); chk("async_bcnt", bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, 32'($urandom_range(0, 40)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
